gf128_multiplier: RTL and testbench

//  Pipelined GF(2^128) multiplier using GCM/GHASH bit ordering (NIST SP 800-38D).
//  It computes result = a * b mod (x^128 + x^7 + x^2 + x + 1).
//  It is the core multiply of the GHASH datapath in the AES-GCM engine.

---
 rtl/gf128_multiplier_if.sv | 22 ++
 rtl/gf128_multiplier.sv | 73 +++++++
 tb/tb_gf128_multiplier.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/gf128_multiplier_if.sv
// Operand/result bundle for the pipelined GHASH multiplier.
// The master drives the operands and the advance enable. The slave returns the products.
interface gf128_multiplier_if #(
    parameter int WIDTH = 128
);
    logic             en;
    logic             valid_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             valid_o;
    logic [WIDTH-1:0] result_o;

    modport master (
        output en, valid_i, a_i, b_i,
        input  valid_o, result_o
    );

    modport slave (
        input  en, valid_i, a_i, b_i,
        output valid_o, result_o
    );
endinterface

// File: rtl/gf128_multiplier.sv
// Pipelined GF(2^128) multiply in GCM bit order: result = a * b mod (x^128 + x^7 + x^2 + x + 1).
// Each of STAGES stages consumes WIDTH/STAGES bits of a, and a final result register follows the last stage.
module gf128_multiplier #(
    parameter int WIDTH  = 128,
    parameter int STAGES = 8
) (
    input  logic               clk,
    input  logic               rst,
    gf128_multiplier_if.slave  bus
);
    localparam int K = WIDTH / STAGES;
    localparam logic [WIDTH-1:0] R = {8'hE1, {(WIDTH-8){1'b0}}};

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] z;
        logic [WIDTH-1:0] v;
        logic [WIDTH-1:0] a;
    } stage_t;

    stage_t           pipe [STAGES];
    stage_t           nxt  [STAGES-1];
    logic [WIDTH-1:0] last_z;
    logic             res_valid;
    logic [WIDTH-1:0] res;

    // K iterations of the shift-and-reduce loop. Bit 127 of a is always the next bit to consume.
    function automatic stage_t run_k(input stage_t s);
        stage_t t;
        t = s;
        for (int i = 0; i < K; i++) begin
            if (t.a[WIDTH-1]) t.z = t.z ^ t.v;
            t.v = t.v[0] ? ((t.v >> 1) ^ R) : (t.v >> 1);
            t.a = t.a << 1;
        end
        return t;
    endfunction

    function automatic logic [WIDTH-1:0] final_z(input stage_t s);
        stage_t t;
        t = run_k(s);
        return t.z;
    endfunction

    always_comb begin
        for (int s = 0; s < STAGES - 1; s++) begin
            nxt[s] = run_k(pipe[s]);
        end
        last_z = final_z(pipe[STAGES-1]);
    end

    // Bubbles travel through the pipeline like real operations. Only the valid bit marks them as empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                pipe[s] <= '0;
            end
            res_valid <= 1'b0;
            res       <= '0;
        end else if (bus.en) begin
            pipe[0] <= '{vld: bus.valid_i, z: '0, v: bus.b_i, a: bus.a_i};
            for (int s = 1; s < STAGES; s++) begin
                pipe[s] <= nxt[s-1];
            end
            res_valid <= pipe[STAGES-1].vld;
            res       <= last_z;
        end
    end

    // Gating with en stops a frozen result from being reported a second time.
    assign bus.valid_o  = res_valid & bus.en;
    assign bus.result_o = res;
endmodule

// File: tb/tb_gf128_multiplier.sv
// Bench for gf128_multiplier. A scoreboard queue holds each product with the enabled-edge index at which it was issued.
// Every cycle the bench checks valid_o, plus result_o whenever a product is due.
module tb_gf128_multiplier;
    localparam int WIDTH  = 128;
    localparam int STAGES = 8;
    localparam logic [WIDTH-1:0] R = {8'hE1, {(WIDTH-8){1'b0}}};

    typedef struct {
        logic [WIDTH-1:0] exp;
        int               when;
    } sb_t;

    logic clk;
    logic rst;
    gf128_multiplier_if #(.WIDTH(WIDTH)) bus ();

    gf128_multiplier #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sb_t sb[$];
    int  checks   = 0;
    int  errors   = 0;
    int  en_count = 0;

    always #5 clk = ~clk;

    // Bit-serial reference algorithm taken directly from the GCM definition.
    function automatic logic [WIDTH-1:0] gf_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] z;
        logic [WIDTH-1:0] v;
        z = '0;
        v = b;
        for (int i = 0; i < WIDTH; i++) begin
            if (a[WIDTH-1-i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ R) : (v >> 1);
        end
        return z;
    endfunction

    function automatic logic [WIDTH-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_val(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs after each edge. A product is due once STAGES enabled edges have passed since its issue.
    task automatic check_output(input string tag);
        logic exp_v;
        exp_v = bus.en && (sb.size() > 0) && (sb[0].when + STAGES == en_count);
        check_val({tag, " valid_o"}, {{(WIDTH-1){1'b0}}, bus.valid_o}, {{(WIDTH-1){1'b0}}, exp_v});
        if (exp_v) begin
            check_val({tag, " result_o"}, bus.result_o, sb[0].exp);
            void'(sb.pop_front());
        end
    endtask

    task automatic apply_stimulus(input string tag, input logic en_v, input logic valid_v,
                                  input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v,
                                  input logic [WIDTH-1:0] exp);
        bus.en      = en_v;
        bus.valid_i = valid_v;
        bus.a_i     = a_v;
        bus.b_i     = b_v;
        if (en_v) en_count++;
        if (en_v && valid_v) sb.push_back('{exp, en_count});
        @(posedge clk);
        #1;
        check_output(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) apply_stimulus(tag, 1'b1, 1'b0, '0, '0, '0);
    endtask

    task automatic issue(input string tag, input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v);
        apply_stimulus(tag, 1'b1, 1'b1, a_v, b_v, gf_mul(a_v, b_v));
    endtask

    // Reset discards everything in flight, so the scoreboard is cleared along with the pipeline.
    task automatic do_reset(input string tag);
        rst         = 1'b1;
        bus.en      = 1'b1;
        bus.valid_i = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_val({tag, " valid_o"}, {{(WIDTH-1){1'b0}}, bus.valid_o}, '0);
        check_val({tag, " result_o"}, bus.result_o, '0);
    endtask

    initial begin
        logic [WIDTH-1:0] ta;
        logic [WIDTH-1:0] tb;
        clk         = 1'b0;
        rst         = 1'b1;
        bus.en      = 1'b0;
        bus.valid_i = 1'b0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        do_reset("reset0");
        do_reset("reset1");

        $display("[TB] directed vectors");
        apply_stimulus("identity", 1'b1, 1'b1, 128'h80000000_00000000_00000000_00000000,
                       128'h0388dace60b6a392f328c2b971b2fe78, 128'h0388dace60b6a392f328c2b971b2fe78);
        apply_stimulus("reduction", 1'b1, 1'b1, 128'h40000000_00000000_00000000_00000000,
                       128'h00000000_00000000_00000000_00000001, 128'hE1000000_00000000_00000000_00000000);
        apply_stimulus("gcm_tc2", 1'b1, 1'b1, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                       128'h0388dace60b6a392f328c2b971b2fe78, 128'h5e2ec746917062882c85b0685353deb7);
        apply_stimulus("gcm_tc2_swap", 1'b1, 1'b1, 128'h0388dace60b6a392f328c2b971b2fe78,
                       128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h5e2ec746917062882c85b0685353deb7);
        apply_stimulus("zero", 1'b1, 1'b1, '0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, '0);
        idle("drain_dir", STAGES + 2);

        $display("[TB] back-to-back random");
        for (int i = 0; i < 10; i++) issue("rand", rand128(), rand128());
        idle("drain_rand", STAGES + 2);

        $display("[TB] stall and bubbles");
        issue("stall", rand128(), rand128());
        apply_stimulus("stall", 1'b1, 1'b0, rand128(), rand128(), '0);
        issue("stall", rand128(), rand128());
        issue("stall", rand128(), rand128());
        for (int i = 0; i < STAGES - 2; i++) issue("stall", rand128(), rand128());
        for (int i = 0; i < 3; i++) apply_stimulus("stalled", 1'b0, 1'b1, rand128(), rand128(), '0);
        issue("stall", rand128(), rand128());
        apply_stimulus("stall", 1'b1, 1'b0, rand128(), rand128(), '0);
        ta = rand128();
        tb = rand128();
        issue("stall_ab", ta, tb);
        issue("stall_ba", tb, ta);
        idle("drain_stall", STAGES + 2);

        $display("[TB] reset mid-flight");
        for (int i = 0; i < 4; i++) issue("flight", rand128(), rand128());
        do_reset("reset_mid");
        issue("post_reset", rand128(), rand128());
        idle("drain_reset", STAGES + 2);

        check_val("sb_empty", WIDTH'(sb.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
